// File: rtl/gf180mcu_fd_sc_mcu7t5v0__mux4_rr_arb.sv
// Round-robin arbiter for a shared 4:1 mux cell.
// Drives the mux select pair S1/S0 and returns a registered one-hot grant.
// A tenure limit forces rotation when others wait. An optional dead gap
// between grants gives break-before-make switching of the mux output.
module gf180mcu_fd_sc_mcu7t5v0__mux4_rr_arb #(
  parameter int HOLD_MAX = 8,
  parameter int SW_GAP   = 1
) (
  input  logic       CLK,
  input  logic       RN,
  input  logic [3:0] REQ,
  output logic [3:0] GNT,
  output logic       S0,
  output logic       S1,
  output logic       ZV,
  output logic       BUSY
);

  localparam int TW = $clog2(HOLD_MAX + 1);
  localparam logic [TW-1:0] TEN_MAX  = TW'(HOLD_MAX);
  localparam logic [1:0]    GAP_INIT = (SW_GAP > 0) ? 2'(SW_GAP - 1) : 2'd0;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t        state, state_n;
  logic [1:0]    last, last_n;
  logic [TW-1:0] ten, ten_n;
  logic [1:0]    gcnt, gcnt_n;
  logic [3:0]    gnt_n;
  logic [1:0]    sel_n;
  logic [2:0]    arb;
  logic          do_arb;
  logic          give_up;

  // Round-robin pick: {found, index}. Scans from lowest priority (prev itself)
  // up to highest (prev+1) so the final hit is the highest-priority requester.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] prev);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = prev + 2'(k);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Next-state logic: release/preempt handling, gap countdown, arbitration.
  always_comb begin
    state_n = state;
    last_n  = last;
    ten_n   = ten;
    gcnt_n  = gcnt;
    gnt_n   = GNT;
    sel_n   = {S1, S0};
    arb     = rr_pick(REQ, last);
    do_arb  = 1'b0;
    // Release wins over preempt, but both end the tenure identically.
    give_up = !REQ[last] ||
              ((ten == TEN_MAX) && ((REQ & ~(4'b0001 << last)) != 4'b0000));

    case (state)
      IDLE: do_arb = 1'b1;
      GRANT: begin
        if (give_up) begin
          gnt_n = 4'b0000;
          ten_n = '0;
          if (SW_GAP > 0) begin
            state_n = GAP;
            gcnt_n  = GAP_INIT;
          end else begin
            do_arb = 1'b1;
          end
        end else if (ten != TEN_MAX) begin
          ten_n = ten + 1'b1;
        end
      end
      GAP: begin
        if (gcnt == 2'd0) do_arb = 1'b1;
        else              gcnt_n = gcnt - 2'd1;
      end
      default: state_n = IDLE;
    endcase

    // Select lines only move together with a fresh grant, never mid-tenure.
    if (do_arb) begin
      if (arb[2]) begin
        state_n = GRANT;
        gnt_n   = 4'b0001 << arb[1:0];
        sel_n   = arb[1:0];
        last_n  = arb[1:0];
        ten_n   = TW'(1);
      end else begin
        state_n = IDLE;
        gnt_n   = 4'b0000;
        ten_n   = '0;
      end
    end
  end

  // State and output registers; reset clears grant and select at once.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state    <= IDLE;
      last     <= 2'd3;
      ten      <= '0;
      gcnt     <= 2'd0;
      GNT      <= 4'b0000;
      {S1, S0} <= 2'b00;
      ZV       <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      state    <= state_n;
      last     <= last_n;
      ten      <= ten_n;
      gcnt     <= gcnt_n;
      GNT      <= gnt_n;
      {S1, S0} <= sel_n;
      ZV       <= |gnt_n;
      BUSY     <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__mux4_rr_arb.sv
// Bench for the round-robin mux arbiter. Three instances with different
// tenure/gap settings share clock, reset and requests; each is tracked by a
// behavioural model that reasons in owners, held cycles and dead cycles.
module tb_gf180mcu_fd_sc_mcu7t5v0__mux4_rr_arb;

  localparam int NI = 3;

  logic       CLK = 1'b0;
  logic       RN  = 1'b1;
  logic [3:0] REQ = 4'b0000;
  logic [3:0] gnt  [NI];
  logic       s0   [NI];
  logic       s1   [NI];
  logic       zv   [NI];
  logic       busy [NI];

  int total = 0;
  int bad   = 0;

  int m_own  [NI];
  int m_held [NI];
  int m_dead [NI];
  int m_last [NI];
  int m_sel  [NI];

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] s;
  } vec_t;

  always #5 CLK = ~CLK;

  gf180mcu_fd_sc_mcu7t5v0__mux4_rr_arb #(.HOLD_MAX(8), .SW_GAP(1)) u0 (
    .CLK(CLK), .RN(RN), .REQ(REQ), .GNT(gnt[0]), .S0(s0[0]), .S1(s1[0]),
    .ZV(zv[0]), .BUSY(busy[0]));
  gf180mcu_fd_sc_mcu7t5v0__mux4_rr_arb #(.HOLD_MAX(4), .SW_GAP(0)) u1 (
    .CLK(CLK), .RN(RN), .REQ(REQ), .GNT(gnt[1]), .S0(s0[1]), .S1(s1[1]),
    .ZV(zv[1]), .BUSY(busy[1]));
  gf180mcu_fd_sc_mcu7t5v0__mux4_rr_arb #(.HOLD_MAX(4), .SW_GAP(2)) u2 (
    .CLK(CLK), .RN(RN), .REQ(REQ), .GNT(gnt[2]), .S0(s0[2]), .S1(s1[2]),
    .ZV(zv[2]), .BUSY(busy[2]));

  function automatic int hold_of(input int k);
    return (k == 0) ? 8 : 4;
  endfunction

  function automatic int gap_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 2);
  endfunction

  function automatic int oh2i(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    m_own[k]  = -1;
    m_held[k] = 0;
    m_dead[k] = 0;
    m_last[k] = 3;
    m_sel[k]  = 0;
  endtask

  // Highest priority is the requester just after the last winner.
  task automatic model_arb(input int k, input logic [3:0] r);
    int i;
    m_own[k] = -1;
    for (int j = 1; j <= 4; j++) begin
      i = (m_last[k] + j) % 4;
      if (r[i]) begin
        m_own[k]  = i;
        m_last[k] = i;
        m_sel[k]  = i;
        m_held[k] = 1;
        break;
      end
    end
  endtask

  task automatic model_step(input int k, input logic [3:0] r);
    logic [3:0] others;
    if (m_own[k] >= 0) begin
      others = r & ~(4'b0001 << m_own[k]);
      if (!r[m_own[k]] || (m_held[k] >= hold_of(k) && others != 4'b0000)) begin
        m_own[k]  = -1;
        m_held[k] = 0;
        if (gap_of(k) > 0) m_dead[k] = gap_of(k);
        else               model_arb(k, r);
      end else if (m_held[k] < hold_of(k)) begin
        m_held[k]++;
      end
    end else if (m_dead[k] > 0) begin
      m_dead[k]--;
      if (m_dead[k] == 0) model_arb(k, r);
    end else begin
      model_arb(k, r);
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0] eg;
    for (int k = 0; k < NI; k++) begin
      eg = (m_own[k] >= 0) ? (4'b0001 << m_own[k]) : 4'b0000;
      chk($sformatf("%s u%0d gnt", tag, k), gnt[k], eg);
      chk($sformatf("%s u%0d sel", tag, k), {s1[k], s0[k]}, m_sel[k]);
      chk($sformatf("%s u%0d zv", tag, k), zv[k], (m_own[k] >= 0));
      chk($sformatf("%s u%0d busy", tag, k), busy[k], (m_own[k] >= 0 || m_dead[k] > 0));
      chk($sformatf("%s u%0d onehot", tag, k), ($countones(gnt[k]) <= 1), 1);
    end
  endtask

  // One clock edge: advance the models with the request seen at the edge.
  task automatic cyc(input string tag);
    @(posedge CLK);
    for (int k = 0; k < NI; k++) begin
      if (RN) model_step(k, REQ);
      else    model_reset(k);
    end
    #1;
    check_model(tag);
  endtask

  task automatic do_reset(input logic [3:0] r);
    REQ = r;
    RN  = 1'b0;
    for (int k = 0; k < NI; k++) model_reset(k);
    cyc("rst");
    cyc("rst");
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst u%0d gnt", k), gnt[k], 4'b0000);
      chk($sformatf("rst u%0d sel", k), {s1[k], s0[k]}, 2'b00);
      chk($sformatf("rst u%0d zv", k), zv[k], 1'b0);
      chk($sformatf("rst u%0d busy", k), busy[k], 1'b0);
    end
    RN = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [15];
    int   order [5];
    logic [3:0] prev;
    int   n, zeros, pend;

    // Preempt with HOLD_MAX=4, SW_GAP=0 (instance u1), then release/idle.
    tbl = '{
      '{4'b0011, 4'b0001, 2'd0}, '{4'b0011, 4'b0001, 2'd0},
      '{4'b0011, 4'b0001, 2'd0}, '{4'b0011, 4'b0001, 2'd0},
      '{4'b0011, 4'b0010, 2'd1}, '{4'b0011, 4'b0010, 2'd1},
      '{4'b0011, 4'b0010, 2'd1}, '{4'b0011, 4'b0010, 2'd1},
      '{4'b0011, 4'b0001, 2'd0}, '{4'b0011, 4'b0001, 2'd0},
      '{4'b0011, 4'b0001, 2'd0}, '{4'b0011, 4'b0001, 2'd0},
      '{4'b0010, 4'b0010, 2'd1}, '{4'b0000, 4'b0000, 2'd1},
      '{4'b1000, 4'b1000, 2'd3}
    };
    order = '{0, 1, 2, 3, 0};

    #1;
    // Reset and first grant.
    do_reset(4'b1111);
    cyc("first");
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("first u%0d gnt", k), gnt[k], 4'b0001);
      chk($sformatf("first u%0d sel", k), {s1[k], s0[k]}, 2'b00);
    end

    // Table-driven preempt / release sequence.
    do_reset(4'b0000);
    for (int i = 0; i < 15; i++) begin
      REQ = tbl[i].req;
      cyc("tbl");
      chk($sformatf("tbl[%0d] u1 gnt", i), gnt[1], tbl[i].gnt);
      chk($sformatf("tbl[%0d] u1 sel", i), {s1[1], s0[1]}, tbl[i].s);
    end

    // Round-robin rotation on u0: drop 3 cycles into a grant, re-raise 1 later.
    do_reset(4'b1111);
    prev = 4'b0000; n = 0; zeros = 0; pend = -1;
    for (int c = 0; c < 60 && n < 5; c++) begin
      cyc("rot");
      if (gnt[0] != 4'b0000 && gnt[0] != prev) begin
        chk($sformatf("rot order[%0d]", n), oh2i(gnt[0]), order[n]);
        chk($sformatf("rot sel[%0d]", n), {s1[0], s0[0]}, order[n]);
        if (n > 0) chk($sformatf("rot dead[%0d]", n), zeros, 1);
        n++;
        zeros = 0;
      end else if (gnt[0] == 4'b0000) begin
        zeros++;
      end
      prev = gnt[0];
      if (pend >= 0) begin REQ[pend] = 1'b1; pend = -1; end
      if (m_own[0] >= 0 && m_held[0] == 3) begin
        REQ[m_own[0]] = 1'b0;
        pend = m_own[0];
      end
    end
    chk("rot grants seen", n, 5);

    // Sole requester saturation on u1, then a newcomer preempts at once.
    do_reset(4'b0100);
    for (int i = 0; i < 20; i++) begin
      cyc("sat");
      chk($sformatf("sat[%0d] u1 gnt", i), gnt[1], 4'b0100);
      chk($sformatf("sat[%0d] u1 sel", i), {s1[1], s0[1]}, 2'b10);
    end
    REQ = 4'b0101;
    cyc("sat_pre");
    chk("sat_pre u1 gnt", gnt[1], 4'b0001);
    chk("sat_pre u1 sel", {s1[1], s0[1]}, 2'b00);

    // Release and preempt on the same edge, SW_GAP=2 (u2).
    do_reset(4'b1001);
    for (int i = 0; i < 4; i++) cyc("coin");
    chk("coin u2 gnt held", gnt[2], 4'b0001);
    REQ = 4'b1000;
    cyc("coin");
    chk("coin u2 dead1 gnt", gnt[2], 4'b0000);
    chk("coin u2 dead1 busy", busy[2], 1'b1);
    cyc("coin");
    chk("coin u2 dead2 gnt", gnt[2], 4'b0000);
    chk("coin u2 dead2 busy", busy[2], 1'b1);
    cyc("coin");
    chk("coin u2 next gnt", gnt[2], 4'b1000);
    chk("coin u2 next sel", {s1[2], s0[2]}, 2'b11);

    // Mid-grant asynchronous reset pulse.
    do_reset(4'b0010);
    cyc("mid");
    chk("mid u0 gnt before", gnt[0], 4'b0010);
    #2;
    RN = 1'b0;
    for (int k = 0; k < NI; k++) model_reset(k);
    #1;
    chk("mid u0 gnt async", gnt[0], 4'b0000);
    chk("mid u0 sel async", {s1[0], s0[0]}, 2'b00);
    chk("mid u0 zv async", zv[0], 1'b0);
    check_model("mid_async");
    #1;
    RN = 1'b1;
    cyc("mid");
    chk("mid u0 gnt after", gnt[0], 4'b0010);
    chk("mid u0 sel after", {s1[0], s0[0]}, 2'b01);

    // Randomized requests with occasional reset pulses.
    do_reset(4'b0000);
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) REQ[b] = ~REQ[b];
      if ($urandom_range(0, 299) == 0) begin
        RN = 1'b0;
        for (int k = 0; k < NI; k++) model_reset(k);
        #1;
        check_model("rnd_rst");
        #1;
        RN = 1'b1;
      end
      cyc("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__mux4_rr_arb.md
# gf180mcu_fd_sc_mcu7t5v0__mux4_rr_arb

Round-robin arbiter that shares one 4:1 mux cell among four requesters. It drives the mux select pair S1/S0 and returns a one-hot grant to each requester. A tenure limit stops any one requester from holding the mux indefinitely. An optional dead gap between grants gives break-before-make switching of the mux output Z.

## Interface
Parameters:
- HOLD_MAX, default 8: maximum grant tenure in cycles before forced rotation when others are pending. Legal range 1..255.
- SW_GAP, default 1: dead cycles between consecutive grants. Legal range 0..3.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RN  input  1  reset. Asynchronous and active-low: assertion clears state immediately, release is sampled on CLK.
- REQ  input  4  request, bit i for mux input Ii. A requester holds its bit high until it is done.
- GNT  output  4  one-hot grant, registered. All-zero when no grant is active.
- S0  output  1  mux select bit 0, registered.
- S1  output  1  mux select bit 1, registered.
- ZV  output  1  Z valid; equals OR of GNT.
- BUSY  output  1  high in GRANT or GAP state.

## Operation
- State machine states: IDLE, GRANT, GAP.
- Internal state:
  - LAST: 2 bits, index of the most recent winner.
  - TEN: tenure counter, width clog2(HOLD_MAX+1), saturating at HOLD_MAX.
  - GCNT: 2-bit gap counter.
- Arbitration is round-robin. Priority order is LAST+1, LAST+2, LAST+3, LAST, all mod 4, evaluated on the current REQ.
- IDLE:
  - GNT=0, ZV=0; S1/S0 hold their values.
  - If REQ≠0: winner W is loaded, GNT=1<<W, {S1,S0}=W, LAST=W, TEN=1, next state GRANT.
- GRANT, with W=LAST:
  - Release: REQ[W]=0 at the edge.
    - GNT clears and TEN clears.
    - If SW_GAP>0: go to GAP with GCNT=SW_GAP-1.
    - If SW_GAP=0: re-arbitrate on the same edge. Go directly to GRANT for a new winner, or to IDLE if REQ=0.
  - Preempt: TEN==HOLD_MAX and (REQ & ~(1<<W))≠0. Handled exactly like release; the preempted requester keeps REQ high and competes again at lowest priority.
  - Release and preempt on the same edge: treated as a single release, with identical outcome.
  - Otherwise: TEN increments, saturating at HOLD_MAX. With no other requester pending, the grant continues indefinitely.
- GAP:
  - GNT=0, ZV=0; S1/S0 hold the previous value.
  - If GCNT=0 at the edge: arbitrate on the current REQ and go to GRANT, or to IDLE if REQ=0.
  - Otherwise GCNT decrements.
- S1/S0 change only on an edge where a new GNT bit is set. They never change while GNT≠0, so Z is glitch-free for the granted requester.
- REQ bits that rise during GAP or GRANT are simply evaluated at the next arbitration point.
- Reset values: GNT=0, S0=0, S1=0, ZV=0, BUSY=0, state IDLE, LAST=3 (first winner has priority 0), TEN=0, GCNT=0.
- Reset asserted mid-grant drops GNT/ZV asynchronously. No grant is issued until the first edge after RN is released.

## Timing
- Request-to-grant latency from IDLE: REQ high before edge n → GNT and S valid after edge n (1 cycle).
- Release-to-drop: REQ[W] low before edge k → GNT[W] low after edge k.
  - With SW_GAP=g>0, the next grant appears after edge k+g.
  - With SW_GAP=0, the next grant appears after edge k itself, with no dead cycle.
- Preempt: a grant issued at edge n is removed at edge n+HOLD_MAX, provided another request is pending.
- GNT is never multi-hot.
- GNT, S0, S1, ZV and BUSY are all register outputs. They have no combinational path from REQ.

## Test plan
- Reset/first grant:
  - Stimulus: RN low, REQ=4'b1111; release RN.
  - Response: GNT=0001, S1S0=00 one edge after release; all outputs 0 during reset.
- Round-robin rotation:
  - Stimulus: HOLD_MAX=8, SW_GAP=1, REQ=1111; each requester drops its REQ 3 cycles into its grant and re-raises it 1 cycle later.
  - Response: grant order 0,1,2,3,0. Exactly one GNT=0 cycle between grants. S1S0 steps 00,01,10,11.
- Preempt:
  - Stimulus: REQ=0011 held constant, HOLD_MAX=4, SW_GAP=0.
  - Response: GNT alternates 0001 ×4 cycles, 0010 ×4 cycles, and so on. No dead cycles; S0 toggles on every switch.
- Sole requester saturation:
  - Stimulus: REQ=0100 for 20 cycles, HOLD_MAX=4.
  - Response: GNT=0100 for all 20 cycles, TEN stuck at 4, S1S0=10.
- Release and preempt coincident:
  - Stimulus: REQ=1001 with GNT=0001; on the cycle TEN reaches HOLD_MAX, REQ[0] also drops; SW_GAP=2.
  - Response: 2 dead cycles, then GNT=1000, S1S0=11.
- Mid-grant reset:
  - Stimulus: GNT=0010 active; pulse RN low between edges.
  - Response: GNT/S/ZV go to 0 immediately, without waiting for CLK. After RN is released with REQ=0010, GNT=0010 one edge later.
